snitch_resp_reorder: RTL and testbench
======================================

SNITCH_RESP_REORDER -- requirements
Module: snitch_resp_reorder

Interface
REQ-001 SHALL have parameter NumOutstanding, default 8, meaning the maximum number of in-flight requests (power of two, 2..2048).
REQ-002 SHALL have parameter DataWidth, default 32, meaning the response data width.
REQ-003 SHALL have parameter InOrder, default 1, meaning 1 = reorder responses into issue order and 0 = pass through out of order.
REQ-004 SHALL have derived parameter IdWidth = idx_width(NumOutstanding).
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-006 SHALL have port rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-007 SHALL have port core_q_valid_i / core_q_ready_o, in/out, 1 each, meaning the core request handshake.
REQ-008 SHALL have port mem_q_valid_o / mem_q_ready_i, out/in, 1 each, meaning the memory request handshake.
REQ-009 SHALL have port mem_q_id_o, output, IdWidth, meaning the ID allocated to the current request.
REQ-010 SHALL have port mem_p_valid_i, input, 1, meaning a memory response is valid; it is always accepted and has no ready.
REQ-011 SHALL have ports mem_p_id_i (IdWidth), mem_p_data_i (DataWidth) and mem_p_error_i (1), all inputs, meaning the memory response payload.
REQ-012 SHALL have port core_p_valid_o / core_p_ready_i, out/in, 1 each, meaning the core response handshake.
REQ-013 SHALL have ports core_p_data_o (DataWidth), core_p_error_o (1) and core_p_id_o (IdWidth), all outputs, meaning the core response payload.
REQ-014 SHALL have port empty_o, output, 1, meaning no request is outstanding.

Function
REQ-015 SHALL be a circular buffer of NumOutstanding entries, each holding a done bit, data and error, with tail (allocate) and head (retire) pointers and a count of 0..NumOutstanding.
REQ-016 SHALL combinationally pass the request handshake through: mem_q_valid_o = core_q_valid_i & ~full and core_q_ready_o = mem_q_ready_i & ~full, where full = (count == NumOutstanding).
REQ-017 SHALL drive mem_q_id_o = tail; on a mem_q handshake, tail increments modulo NumOutstanding and the entry's done bit clears.
REQ-018 SHALL, on mem_p_valid_i in InOrder=1, write data and error to entry[mem_p_id_i] and set its done bit, visible on the following cycle (1-cycle latency, no same-cycle bypass).
REQ-019 SHALL, in InOrder=1, assert core_p_valid_o = done[head] & (count != 0), drive payload from entry[head] and core_p_id_o = head, and on handshake increment head and clear done[head].
REQ-020 SHALL, in InOrder=0, register the memory response into a single-entry output register (valid, data, error, id); while that register is full and core_p_ready_i is low, further responses go to the buffer entry for their ID and drain in arrival order.
REQ-021 SHALL update count by +1 on allocation, -1 on retirement, and leave it unchanged when both occur in the same cycle.
REQ-022 SHALL accept a new request in the same cycle the oldest entry retires, except when full, where ready stays low that cycle because full is evaluated before retirement.
REQ-023 SHALL hold core_p_valid_o and its payload stable until handshake once asserted.
REQ-024 SHALL ignore a response whose ID is not outstanding or is already done, and SHALL flag it with a simulation-only assertion.
REQ-025 SHALL wrap both pointers from NumOutstanding-1 to 0 with no loss of entries.
REQ-026 SHALL drive empty_o = (count == 0) and leave it undriven by pending InOrder=0 output-register contents.

Reset
REQ-027 SHALL, while rst_ni is low, asynchronously clear head, tail, count, all done bits and the output register, so that mem_q_valid_o = 0, core_p_valid_o = 0, core_q_ready_o = 0, empty_o = 1 and IDs = 0.
REQ-028 SHALL treat reset asserted mid-operation as discarding all outstanding entries, and SHALL ignore any response that arrives after deassertion for a pre-reset ID.

Structure
REQ-029 SHALL import the snitch_pkg constants NumIntOutstandingLoads (default for NumOutstanding) and meta_id_t (ID type when widths match) and add nothing else to the package.
REQ-030 SHALL be flat, with one optional sub-module snitch_reorder_entry_mem holding the per-entry storage array (write port by ID, read port by head).

Verification
REQ-031 SHALL cover: issue IDs 0,1,2; respond in order 2,0,1 with data 0xA2,0xA0,0xA1 -> core sees 0xA0,0xA1,0xA2 in order, first one 1 cycle after the ID0 response.
REQ-032 SHALL cover: 8 requests without responses (NumOutstanding=8) -> core_q_ready_o=0 at the 9th; respond ID0 and retire -> the 9th is accepted with mem_q_id_o=0.
REQ-033 SHALL cover: 20 back-to-back request/response pairs with core_p_ready_i=1 -> IDs wrap 7->0, count never exceeds 1, data matches order.
REQ-034 SHALL cover: core_p_ready_i=0 for 10 cycles with head done -> core_p_valid_o stays 1 with stable data 0xDEAD.
REQ-035 SHALL cover: InOrder=0, responses 3 then 1 -> core sees ID3 then ID1 with matching data and error bit.
REQ-036 SHALL cover: reset asserted with 5 outstanding, then a stale response ID2 -> empty_o=1 and core_p_valid_o stays 0.

Source files
------------

// File: rtl/snitch_pkg.sv
// Shared Snitch constants: default load-tracking depth and the matching ID type.
package snitch_pkg;
    localparam int unsigned NumIntOutstandingLoads = 8;
    typedef logic [$clog2(NumIntOutstandingLoads)-1:0] meta_id_t;
endpackage

// File: rtl/snitch_reorder_entry_mem.sv
// Per-entry response payload storage: written by response ID, read by retire index.
module snitch_reorder_entry_mem #(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 3
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [IdWidth-1:0]   waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 werror_i,
    input  logic [IdWidth-1:0]   raddr_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rerror_o
);
    logic [DataWidth-1:0] data_q  [NumOutstanding];
    logic                 error_q [NumOutstanding];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q[waddr_i]  <= wdata_i;
            error_q[waddr_i] <= werror_i;
        end
    end

    assign rdata_o  = data_q[raddr_i];
    assign rerror_o = error_q[raddr_i];
endmodule

// File: rtl/snitch_resp_reorder.sv
// Tracks outstanding memory requests by ID and returns responses to the core,
// either in issue order (InOrder=1) or in arrival order (InOrder=0).
module snitch_resp_reorder
    import snitch_pkg::*;
#(
    parameter int unsigned NumOutstanding = NumIntOutstandingLoads,
    parameter int unsigned DataWidth      = 32,
    parameter bit          InOrder        = 1'b1,
    parameter int unsigned IdWidth        = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_q_valid_i,
    output logic                 core_q_ready_o,
    output logic                 mem_q_valid_o,
    input  logic                 mem_q_ready_i,
    output logic [IdWidth-1:0]   mem_q_id_o,
    input  logic                 mem_p_valid_i,
    input  logic [IdWidth-1:0]   mem_p_id_i,
    input  logic [DataWidth-1:0] mem_p_data_i,
    input  logic                 mem_p_error_i,
    output logic                 core_p_valid_o,
    input  logic                 core_p_ready_i,
    output logic [DataWidth-1:0] core_p_data_o,
    output logic                 core_p_error_o,
    output logic [IdWidth-1:0]   core_p_id_o,
    output logic                 empty_o
);
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
    typedef logic [IdWidth-1:0] id_t;

    id_t                       head_q, head_d, tail_q, tail_d, fr_q, fr_d, fw_q, fw_d;
    logic [CntWidth-1:0]       count_q, count_d, fc_q, fc_d;
    logic [NumOutstanding-1:0] done_q, done_d, pend_q, pend_d;
    logic                      ov_q, ov_d, oe_q, oe_d;
    logic [DataWidth-1:0]      od_q, od_d;
    id_t                       oid_q, oid_d;
    id_t                       fifo_q [NumOutstanding];
    id_t                       fifo_d [NumOutstanding];

    logic                      full, alloc, resp_ok, retire, out_free, pop, direct, mem_we;
    id_t                       rd_idx;
    logic [DataWidth-1:0]      rd_data;
    logic                      rd_error;

    // Full is judged on the registered count, so a retire cannot free a slot in the same cycle.
    assign full           = (count_q == CntWidth'(NumOutstanding));
    assign mem_q_valid_o  = core_q_valid_i & ~full & rst_ni;
    assign core_q_ready_o = mem_q_ready_i & ~full & rst_ni;
    assign mem_q_id_o     = tail_q;
    assign alloc          = core_q_valid_i & mem_q_ready_i & ~full & rst_ni;
    assign resp_ok        = mem_p_valid_i & pend_q[mem_p_id_i];
    assign empty_o        = (count_q == '0);

    snitch_reorder_entry_mem #(
        .NumOutstanding (NumOutstanding),
        .DataWidth      (DataWidth),
        .IdWidth        (IdWidth)
    ) i_entry_mem (
        .clk_i    (clk_i),
        .we_i     (mem_we),
        .waddr_i  (mem_p_id_i),
        .wdata_i  (mem_p_data_i),
        .werror_i (mem_p_error_i),
        .raddr_i  (rd_idx),
        .rdata_o  (rd_data),
        .rerror_o (rd_error)
    );

    always_comb begin
        if (InOrder) begin
            core_p_valid_o = done_q[head_q] & (count_q != '0);
            core_p_data_o  = rd_data;
            core_p_error_o = rd_error;
            core_p_id_o    = head_q;
        end else begin
            core_p_valid_o = ov_q;
            core_p_data_o  = od_q;
            core_p_error_o = oe_q;
            core_p_id_o    = oid_q;
        end
        retire   = core_p_valid_o & core_p_ready_i;
        out_free = ~ov_q | core_p_ready_i;
        pop      = !InOrder && out_free && (fc_q != '0);
        direct   = !InOrder && out_free && (fc_q == '0) && resp_ok;
        mem_we   = resp_ok & ~direct;
        rd_idx   = InOrder ? head_q : fifo_q[fr_q];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        done_d  = done_q;
        pend_d  = pend_q;
        ov_d    = ov_q;
        od_d    = od_q;
        oe_d    = oe_q;
        oid_d   = oid_q;
        fifo_d  = fifo_q;
        fr_d    = fr_q;
        fw_d    = fw_q;
        fc_d    = fc_q;
        count_d = count_q + CntWidth'(alloc) - CntWidth'(retire);

        if (resp_ok) pend_d[mem_p_id_i] = 1'b0;
        if (mem_we)  done_d[mem_p_id_i] = 1'b1;
        if (alloc) begin
            tail_d         = tail_q + id_t'(1);
            pend_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
        end

        if (InOrder) begin
            if (retire) begin
                head_d         = head_q + id_t'(1);
                done_d[head_q] = 1'b0;
            end
        end else begin
            // Responses that cannot enter the output register queue up by arrival order.
            if (mem_we) begin
                fifo_d[fw_q] = mem_p_id_i;
                fw_d         = fw_q + id_t'(1);
            end
            if (out_free) begin
                ov_d = 1'b0;
                if (pop) begin
                    ov_d                 = 1'b1;
                    od_d                 = rd_data;
                    oe_d                 = rd_error;
                    oid_d                = fifo_q[fr_q];
                    fr_d                 = fr_q + id_t'(1);
                    done_d[fifo_q[fr_q]] = 1'b0;
                end else if (direct) begin
                    ov_d  = 1'b1;
                    od_d  = mem_p_data_i;
                    oe_d  = mem_p_error_i;
                    oid_d = mem_p_id_i;
                end
            end
            fc_d = fc_q + CntWidth'(mem_we) - CntWidth'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
            pend_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            oe_q    <= 1'b0;
            oid_q   <= '0;
            fr_q    <= '0;
            fw_q    <= '0;
            fc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            oe_q    <= oe_d;
            oid_q   <= oid_d;
            fr_q    <= fr_d;
            fw_q    <= fw_d;
            fc_q    <= fc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && mem_p_valid_i) begin
            assert (pend_q[mem_p_id_i])
            else $warning("snitch_resp_reorder: dropped response for id %0d that is not outstanding", mem_p_id_i);
        end
    end
`endif
endmodule

// File: tb/tb_snitch_resp_reorder.sv
// Directed bench: an in-order and an out-of-order instance driven by the same stimulus.
module tb_snitch_resp_reorder;
    import snitch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_q_valid, mem_q_ready, mem_p_valid, mem_p_error, core_p_ready;
    meta_id_t    mem_p_id;
    logic [31:0] mem_p_data;

    logic        io_q_ready, io_mq_valid, io_p_valid, io_p_error, io_empty;
    logic [2:0]  io_mq_id, io_p_id;
    logic [31:0] io_p_data;
    logic        oo_q_ready, oo_mq_valid, oo_p_valid, oo_p_error, oo_empty;
    logic [2:0]  oo_mq_id, oo_p_id;
    logic [31:0] oo_p_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snitch_resp_reorder #(.NumOutstanding(8), .DataWidth(32), .InOrder(1'b1)) dut_io (
        .clk_i(clk), .rst_ni(rst_n),
        .core_q_valid_i(core_q_valid), .core_q_ready_o(io_q_ready),
        .mem_q_valid_o(io_mq_valid), .mem_q_ready_i(mem_q_ready), .mem_q_id_o(io_mq_id),
        .mem_p_valid_i(mem_p_valid), .mem_p_id_i(mem_p_id), .mem_p_data_i(mem_p_data),
        .mem_p_error_i(mem_p_error),
        .core_p_valid_o(io_p_valid), .core_p_ready_i(core_p_ready),
        .core_p_data_o(io_p_data), .core_p_error_o(io_p_error), .core_p_id_o(io_p_id),
        .empty_o(io_empty)
    );

    snitch_resp_reorder #(.NumOutstanding(8), .DataWidth(32), .InOrder(1'b0)) dut_oo (
        .clk_i(clk), .rst_ni(rst_n),
        .core_q_valid_i(core_q_valid), .core_q_ready_o(oo_q_ready),
        .mem_q_valid_o(oo_mq_valid), .mem_q_ready_i(mem_q_ready), .mem_q_id_o(oo_mq_id),
        .mem_p_valid_i(mem_p_valid), .mem_p_id_i(mem_p_id), .mem_p_data_i(mem_p_data),
        .mem_p_error_i(mem_p_error),
        .core_p_valid_o(oo_p_valid), .core_p_ready_i(core_p_ready),
        .core_p_data_o(oo_p_data), .core_p_error_o(oo_p_error), .core_p_id_o(oo_p_id),
        .empty_o(oo_empty)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_q_valid = 1'b0; mem_q_ready = 1'b1; mem_p_valid = 1'b0;
        mem_p_id = '0; mem_p_data = '0; mem_p_error = 1'b0; core_p_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic respond(input int id, input logic [31:0] data, input logic err);
        mem_p_valid = 1'b1; mem_p_id = meta_id_t'(id); mem_p_data = data; mem_p_error = err;
    endtask

    task automatic test_reset();
        idle_inputs();
        core_q_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (io_mq_valid !== 1'b0) begin failures++; $display("FAIL reset_mq_valid got=%b exp=0", io_mq_valid); end
        checks++; if (io_q_ready !== 1'b0) begin failures++; $display("FAIL reset_q_ready got=%b exp=0", io_q_ready); end
        checks++; if (io_p_valid !== 1'b0) begin failures++; $display("FAIL reset_p_valid got=%b exp=0", io_p_valid); end
        checks++; if (io_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", io_empty); end
        checks++; if (io_mq_id !== 3'd0) begin failures++; $display("FAIL reset_mq_id got=%0d exp=0", io_mq_id); end
        checks++; if (oo_p_valid !== 1'b0) begin failures++; $display("FAIL reset_oo_p_valid got=%b exp=0", oo_p_valid); end
        do_reset();
    endtask

    task automatic test_reorder();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hA0; exp_data[1] = 32'hA1; exp_data[2] = 32'hA2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(); core_q_valid = 1'b1; #1;
            checks++; if (io_mq_id !== 3'(i)) begin failures++; $display("FAIL reorder_issue_id got=%0d exp=%0d", io_mq_id, i); end
        end
        tick(); core_q_valid = 1'b0; respond(2, 32'hA2, 1'b0);
        tick(); respond(0, 32'hA0, 1'b0); #1;
        checks++; if (io_p_valid !== 1'b0) begin failures++; $display("FAIL reorder_wait_head got=%b exp=0", io_p_valid); end
        tick(); respond(1, 32'hA1, 1'b0); core_p_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (io_p_valid !== 1'b1 || io_p_data !== exp_data[i] || io_p_id !== 3'(i)) begin
                failures++; $display("FAIL reorder_out%0d got v=%b d=%0h id=%0d exp v=1 d=%0h id=%0d", i, io_p_valid, io_p_data, io_p_id, exp_data[i], i);
            end
            tick(); mem_p_valid = 1'b0;
        end
        #1;
        checks++; if (io_p_valid !== 1'b0 || io_empty !== 1'b1) begin failures++; $display("FAIL reorder_drained got v=%b e=%b exp v=0 e=1", io_p_valid, io_empty); end
        core_p_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(); core_q_valid = 1'b1; #1;
            checks++; if (io_q_ready !== 1'b1 || io_mq_id !== 3'(i)) begin failures++; $display("FAIL full_fill%0d got rdy=%b id=%0d exp rdy=1 id=%0d", i, io_q_ready, io_mq_id, i); end
        end
        tick(); respond(0, 32'h55, 1'b0); #1;
        checks++; if (io_q_ready !== 1'b0 || io_mq_valid !== 1'b0) begin failures++; $display("FAIL full_ninth_blocked got rdy=%b v=%b exp 0 0", io_q_ready, io_mq_valid); end
        tick(); mem_p_valid = 1'b0; core_p_ready = 1'b1; #1;
        checks++; if (io_q_ready !== 1'b0) begin failures++; $display("FAIL full_retire_cycle_ready got=%b exp=0", io_q_ready); end
        checks++; if (io_p_valid !== 1'b1 || io_p_data !== 32'h55) begin failures++; $display("FAIL full_retire_data got v=%b d=%0h exp v=1 d=55", io_p_valid, io_p_data); end
        tick(); core_p_ready = 1'b0; #1;
        checks++; if (io_q_ready !== 1'b1 || io_mq_id !== 3'd0) begin failures++; $display("FAIL full_ninth_accept got rdy=%b id=%0d exp rdy=1 id=0", io_q_ready, io_mq_id); end
        tick(); core_q_valid = 1'b0; #1;
        checks++; if (io_q_ready !== 1'b0 || io_empty !== 1'b0) begin failures++; $display("FAIL full_again got rdy=%b e=%b exp 0 0", io_q_ready, io_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        core_p_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            tick(); core_q_valid = 1'b1; mem_p_valid = 1'b0; #1;
            checks++; if (io_q_ready !== 1'b1 || io_mq_id !== 3'(p % 8)) begin failures++; $display("FAIL b2b_issue%0d got rdy=%b id=%0d exp rdy=1 id=%0d", p, io_q_ready, io_mq_id, p % 8); end
            if (p > 0) begin
                checks++; if (io_p_valid !== 1'b1 || io_p_data !== 32'h200 + 32'(p - 1) || io_p_id !== 3'((p - 1) % 8)) begin
                    failures++; $display("FAIL b2b_ret%0d got v=%b d=%0h id=%0d exp v=1 d=%0h id=%0d", p - 1, io_p_valid, io_p_data, io_p_id, 32'h200 + 32'(p - 1), (p - 1) % 8);
                end
            end
            tick(); core_q_valid = 1'b0; respond(p % 8, 32'h200 + 32'(p), 1'b0); #1;
            checks++; if (io_p_valid !== 1'b0 || io_empty !== 1'b0) begin failures++; $display("FAIL b2b_pending%0d got v=%b e=%b exp v=0 e=0", p, io_p_valid, io_empty); end
        end
        tick(); mem_p_valid = 1'b0; #1;
        checks++; if (io_p_valid !== 1'b1 || io_p_data !== 32'h213 || io_p_id !== 3'd3) begin failures++; $display("FAIL b2b_last got v=%b d=%0h id=%0d exp v=1 d=213 id=3", io_p_valid, io_p_data, io_p_id); end
        tick(); #1;
        checks++; if (io_p_valid !== 1'b0 || io_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got v=%b e=%b exp v=0 e=1", io_p_valid, io_empty); end
        core_p_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        tick(); core_q_valid = 1'b1;
        tick(); core_q_valid = 1'b0; respond(0, 32'hDEAD, 1'b0);
        tick(); mem_p_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (io_p_valid !== 1'b1 || io_p_data !== 32'hDEAD) begin failures++; $display("FAIL stall_hold%0d got v=%b d=%0h exp v=1 d=dead", i, io_p_valid, io_p_data); end
            tick();
        end
        core_p_ready = 1'b1;
        tick(); core_p_ready = 1'b0; #1;
        checks++; if (io_p_valid !== 1'b0 || io_empty !== 1'b1) begin failures++; $display("FAIL stall_release got v=%b e=%b exp v=0 e=1", io_p_valid, io_empty); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(); core_q_valid = 1'b1; #1;
            checks++; if (oo_mq_id !== 3'(i)) begin failures++; $display("FAIL ooo_issue_id got=%0d exp=%0d", oo_mq_id, i); end
        end
        tick(); core_q_valid = 1'b0; respond(3, 32'h33, 1'b1);
        tick(); respond(1, 32'h11, 1'b0); #1;
        checks++; if (oo_p_valid !== 1'b1 || oo_p_id !== 3'd3 || oo_p_data !== 32'h33 || oo_p_error !== 1'b1) begin
            failures++; $display("FAIL ooo_first got v=%b id=%0d d=%0h err=%b exp v=1 id=3 d=33 err=1", oo_p_valid, oo_p_id, oo_p_data, oo_p_error);
        end
        tick(); mem_p_valid = 1'b0; core_p_ready = 1'b1; #1;
        checks++; if (oo_p_valid !== 1'b1 || oo_p_id !== 3'd3 || oo_p_data !== 32'h33) begin failures++; $display("FAIL ooo_first_held got v=%b id=%0d d=%0h exp v=1 id=3 d=33", oo_p_valid, oo_p_id, oo_p_data); end
        tick(); #1;
        checks++; if (oo_p_valid !== 1'b1 || oo_p_id !== 3'd1 || oo_p_data !== 32'h11 || oo_p_error !== 1'b0) begin
            failures++; $display("FAIL ooo_second got v=%b id=%0d d=%0h err=%b exp v=1 id=1 d=11 err=0", oo_p_valid, oo_p_id, oo_p_data, oo_p_error);
        end
        tick(); core_p_ready = 1'b0; #1;
        checks++; if (oo_p_valid !== 1'b0 || oo_empty !== 1'b0) begin failures++; $display("FAIL ooo_after got v=%b e=%b exp v=0 e=0", oo_p_valid, oo_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(); core_q_valid = 1'b1;
        end
        tick(); core_q_valid = 1'b0; #1;
        checks++; if (io_empty !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", io_empty); end
        rst_n = 1'b0; #1;
        checks++; if (io_empty !== 1'b1 || io_mq_id !== 3'd0) begin failures++; $display("FAIL midrst_async got e=%b id=%0d exp e=1 id=0", io_empty, io_mq_id); end
        tick(); rst_n = 1'b1; respond(2, 32'hBAD, 1'b0);
        tick(); mem_p_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (io_p_valid !== 1'b0 || io_empty !== 1'b1) begin failures++; $display("FAIL midrst_stale_io%0d got v=%b e=%b exp v=0 e=1", i, io_p_valid, io_empty); end
            checks++; if (oo_p_valid !== 1'b0 || oo_empty !== 1'b1) begin failures++; $display("FAIL midrst_stale_oo%0d got v=%b e=%b exp v=0 e=1", i, oo_p_valid, oo_empty); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_reorder();
        test_full();
        test_back_to_back();
        test_stall();
        test_out_of_order();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
